// File: rtl/adc_osr_pkg.sv
// Shared mode encodings and helpers for the multichannel ADC oversampler.
package adc_osr_pkg;

  localparam int unsigned MODE_W = 3;

  // Mode m averages 4**m samples; bypass passes every sample straight through.
  typedef enum logic [MODE_W-1:0] {
    OSR_BYPASS = 3'd0,
    OSR_X4     = 3'd1,
    OSR_X16    = 3'd2,
    OSR_X64    = 3'd3,
    OSR_X256   = 3'd4,
    OSR_X1K    = 3'd5,
    OSR_X4K    = 3'd6,
    OSR_X16K   = 3'd7
  } osr_mode_e;

  function automatic logic [MODE_W-1:0] osr_clamp(input logic [MODE_W-1:0] mode,
                                                  input int unsigned max_mode);
    if (mode > MODE_W'(max_mode)) return MODE_W'(max_mode);
    return mode;
  endfunction

  function automatic int unsigned osr_limit(input logic [MODE_W-1:0] mode);
    return 32'd1 << {mode, 1'b0};
  endfunction

endpackage

// File: rtl/adc_osr_chan.sv
// One oversampling channel: accumulator, sample counter and latched mode/rounding.
module adc_osr_chan
  import adc_osr_pkg::*;
#(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned MAX_OSR_LOG4 = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_en,
  input  logic [DATA_W-1:0]              data_in,
  input  logic [MODE_W-1:0]              osr_mode_in,
  input  logic                           round_en_in,
  output logic                           done_c,
  output logic [DATA_W+MAX_OSR_LOG4-1:0] result_c
);

  localparam int unsigned OUT_W = DATA_W + MAX_OSR_LOG4;
  localparam int unsigned ACC_W = DATA_W + 2 * MAX_OSR_LOG4;
  localparam int unsigned CNT_W = 2 * MAX_OSR_LOG4;

  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MODE_W-1:0] mode_q;
  logic              round_q;

  logic              first;
  logic [MODE_W-1:0] eff_mode;
  logic              eff_round;
  logic [MODE_W-1:0] lsh;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  rnd_add;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  shifted;

  // A zero count means the next sample starts a fresh conversion and latches the mode inputs.
  always_comb begin
    first     = (cnt_q == '0);
    eff_mode  = first ? osr_clamp(osr_mode_in, MAX_OSR_LOG4) : mode_q;
    eff_round = first ? round_en_in : round_q;
    lsh       = MODE_W'(MAX_OSR_LOG4) - eff_mode;
    acc_next  = first ? ACC_W'(data_in) : acc_q + ACC_W'(data_in);
    rnd_add   = '0;
    if (eff_round && (eff_mode != OSR_BYPASS))
      rnd_add = ACC_W'(1) << (eff_mode - MODE_W'(1));
    sum      = acc_next + rnd_add;
    shifted  = (sum >> eff_mode) << lsh;
    result_c = OUT_W'(shifted);
    done_c   = sample_en && (cnt_q == CNT_W'(osr_limit(eff_mode) - 32'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      round_q <= 1'b0;
    end else if (sample_en) begin
      acc_q <= acc_next;
      cnt_q <= done_c ? '0 : cnt_q + CNT_W'(1);
      if (first) begin
        mode_q  <= eff_mode;
        round_q <= eff_round;
      end
    end
  end

endmodule

// File: rtl/adc_osr_mc.sv
// Multichannel ADC oversampler with a single registered valid/ready result port.
module adc_osr_mc
  import adc_osr_pkg::*;
#(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned MAX_OSR_LOG4 = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           sample_valid_in,
  input  logic [$clog2(CHANNELS)-1:0]    sample_ch_in,
  input  logic [DATA_W-1:0]              data_in,
  input  logic [2:0]                     osr_mode_in,
  input  logic                           round_en_in,
  output logic [DATA_W+MAX_OSR_LOG4-1:0] data_out,
  output logic [$clog2(CHANNELS)-1:0]    data_ch_out,
  output logic                           data_valid_out,
  input  logic                           data_ready_in,
  output logic                           overrun_out
);

  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned OUT_W = DATA_W + MAX_OSR_LOG4;

  logic [CHANNELS-1:0] done_c;
  logic [OUT_W-1:0]    result_c [CHANNELS];

  logic                done_any;
  logic [OUT_W-1:0]    sel_result;
  logic [CH_W-1:0]     sel_ch;
  logic                can_load;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic sample_en;
    assign sample_en = ena && sample_valid_in && (sample_ch_in == CH_W'(i));

    adc_osr_chan #(
      .DATA_W       (DATA_W),
      .MAX_OSR_LOG4 (MAX_OSR_LOG4)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .sample_en   (sample_en),
      .data_in     (data_in),
      .osr_mode_in (osr_mode_in),
      .round_en_in (round_en_in),
      .done_c      (done_c[i]),
      .result_c    (result_c[i])
    );
  end

  // Only one sample arrives per cycle, so at most one channel completes.
  always_comb begin
    done_any   = 1'b0;
    sel_result = '0;
    sel_ch     = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (done_c[i]) begin
        done_any   = 1'b1;
        sel_result = result_c[i];
        sel_ch     = CH_W'(i);
      end
    end
    can_load = !data_valid_out || data_ready_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_ch_out    <= '0;
      data_valid_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      overrun_out <= done_any && !can_load;
      if (done_any && can_load) begin
        data_out       <= sel_result;
        data_ch_out    <= sel_ch;
        data_valid_out <= 1'b1;
      end else if (data_valid_out && data_ready_in) begin
        data_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_osr_mc.md
ADC_OSR_MC -- requirements
Module: adc_osr_mc

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 12, meaning the raw ADC sample width in bits.
REQ-002 The block SHALL expose parameter CHANNELS, default 4, meaning the number of independently oversampled channels (power of two, at least 2).
REQ-003 The block SHALL expose parameter MAX_OSR_LOG4, default 4, meaning the largest supported mode m (4**m samples).
REQ-004 The block SHALL use derived widths CH_W=clog2(CHANNELS), OUT_W=DATA_W+MAX_OSR_LOG4 and ACC_W=DATA_W+2*MAX_OSR_LOG4.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port ena, input, 1 bit: global enable; when low, the block accepts no samples and holds all state.
REQ-008 The block SHALL have port sample_valid_in, input, 1 bit: data_in and sample_ch_in are valid this cycle.
REQ-009 The block SHALL have port sample_ch_in, input, CH_W bits: the channel index of the sample.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: unsigned sample, with 0 = -VCC.
REQ-011 The block SHALL have port osr_mode_in, input, 3 bits: requested mode m, where 0 = bypass.
REQ-012 The block SHALL have port round_en_in, input, 1 bit: round-half-up instead of truncate.
REQ-013 The block SHALL have port data_out, output, OUT_W bits: MSB-aligned oversampled result.
REQ-014 The block SHALL have port data_ch_out, output, CH_W bits: the channel of data_out.
REQ-015 The block SHALL have port data_valid_out, output, 1 bit: data_out holds an unconsumed result.
REQ-016 The block SHALL have port data_ready_in, input, 1 bit: consumer accepts the result when it and data_valid_out are both high.
REQ-017 The block SHALL have port overrun_out, output, 1 bit: one-cycle pulse when a completed result is dropped.

Function
REQ-018 A sample SHALL be accepted iff ena and sample_valid_in are both high in the cycle.
REQ-019 Each channel SHALL hold its own accumulator (ACC_W), sample counter and latched mode.
REQ-020 For the first sample of a channel conversion, the channel SHALL latch osr_mode_in and round_en_in, clamping the mode to MAX_OSR_LOG4; the accumulator SHALL load data_in.
REQ-021 For each subsequent sample, the channel SHALL add data_in to its accumulator; mode-input changes SHALL be ignored until the next first sample.
REQ-022 A conversion SHALL complete on the accepted sample that brings the count to 4**m, with the counter returning to first-sample state in that cycle; mode 0 SHALL complete on every sample.
REQ-023 The result SHALL equal (acc + (round ? 2**(m-1) : 0)) >> m, left-shifted by (MAX_OSR_LOG4-m) into OUT_W bits; for mode 0, the result SHALL be data_in << MAX_OSR_LOG4 with no rounding.
REQ-024 The width rule SHALL guarantee no overflow; the worst case is all-ones with rounding at m=MAX.
REQ-025 The result SHALL appear on data_out/data_ch_out with data_valid_out high in the cycle after the completing sample (1-cycle latency).
REQ-026 data_valid_out SHALL remain high with stable data until accepted, and SHALL then clear next cycle unless a new result loads.
REQ-027 If a completion coincides with acceptance, the new result SHALL load with no bubble and no overrun.
REQ-028 If a completion occurs while valid and not ready, the new result SHALL be discarded, overrun_out SHALL pulse next cycle, the held output SHALL be unchanged, and the channel SHALL restart normally.
REQ-029 Samples for other channels SHALL never disturb a channel's state; interleaving SHALL be arbitrary.
REQ-030 When ena is low, pending output handshake SHALL still complete.

Reset
REQ-031 Asserting rst SHALL clear all accumulators, counters, latched modes, data_out, data_ch_out, data_valid_out and overrun_out to zero, with every channel in first-sample state, regardless of any conversion in progress.
REQ-032 The first accepted sample after release SHALL be treated as a first sample.

Structure
REQ-033 Package adc_osr_pkg SHALL hold the mode encodings, the mode clamp function and the 4**m limit function.
REQ-034 The per-channel accumulator/counter/mode SHALL live in sub-module adc_osr_chan, instantiated CHANNELS times.

Verification
REQ-035 Directed test: ch0 mode 1, no rounding, samples 0x001,0x001,0x001,0x002 -> data_out=0x0010, ch 0, one cycle after the 4th sample; the same with rounding -> 0x0018.
REQ-036 Directed test: ch2 mode 4, round on, 256 samples of 0xFFF -> data_out=0xFFF0; mode 0 with sample 0xABC -> 0xABC0 every sample.
REQ-037 Directed test: interleave ch0 mode 1 and ch1 mode 2 -> ch0 result after 4 ch0 samples, ch1 result after 16 ch1 samples, both correct.
REQ-038 Directed test: hold data_ready_in low with a result pending, then complete a conversion -> overrun_out pulses once and data_out is unchanged; a completion coincident with ready loads without overrun.
REQ-039 Directed test: assert rst after 2 of 4 mode-1 samples -> outputs are zero; the next 4 samples produce a correct, uncorrupted result.
REQ-040 Directed test: change osr_mode_in mid-conversion -> the old mode governs; ena low for 10 cycles -> counters are frozen and samples are ignored.
